// File: rtl/soc_system_pio_in.sv
// Avalon-MM input PIO: synchronized DATA readback, per-bit edge capture (W1C)
// and a level interrupt gated by IRQMASK.
module soc_system_pio_in #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam int CW = $clog2(SYNC_STAGES + 2);
   localparam logic [CW-1:0] PRIME_LOAD = CW'(SYNC_STAGES + 1);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] edgecap_q, edgecap_d;
   logic [WIDTH-1:0] irqmask_q, irqmask_d;
   logic [31:0]      readdata_q, readdata_d;
   logic [CW-1:0]    prime_q, prime_d;

   logic [WIDTH-1:0] sync_w;
   logic [WIDTH-1:0] edge_raw;
   logic [WIDTH-1:0] edge_hit;
   logic [WIDTH-1:0] clr;
   logic             wr_en;
   logic             unused_wdata;

   assign sync_w       = sync_q[SYNC_STAGES-1];
   assign wr_en        = chipselect && !write_n;
   assign unused_wdata = ^writedata;

   always_comb begin
      edge_raw = sync_w & ~prev_q;
      if (EDGE_TYPE == 1)      edge_raw = ~sync_w & prev_q;
      else if (EDGE_TYPE == 2) edge_raw = sync_w ^ prev_q;
   end

   // While priming, the chain is still filling from reset zeros; suppress edges.
   assign edge_hit = (prime_q == '0) ? edge_raw : '0;
   assign prime_d  = (prime_q == '0) ? prime_q : prime_q - 1'b1;

   assign clr       = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
   assign edgecap_d = (edgecap_q & ~clr) | edge_hit;
   assign irqmask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : irqmask_q;

   always_comb begin
      readdata_d = '0;
      case (address)
         2'd0:    readdata_d[WIDTH-1:0] = sync_w;
         2'd2:    readdata_d[WIDTH-1:0] = irqmask_q;
         2'd3:    readdata_d[WIDTH-1:0] = edgecap_q;
         default: readdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         prev_q     <= '0;
         edgecap_q  <= '0;
         irqmask_q  <= '0;
         readdata_q <= '0;
         prime_q    <= PRIME_LOAD;
      end else begin
         sync_q[0] <= in_port;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev_q     <= sync_w;
         edgecap_q  <= edgecap_d;
         irqmask_q  <= irqmask_d;
         readdata_q <= readdata_d;
         prime_q    <= prime_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = |(edgecap_q & irqmask_q);

endmodule
